random_word_packer: RTL and testbench

RANDOM_WORD_PACKER -- requirements
Module: random_word_packer

---
 rtl/random_word_packer_pkg.sv | 20 ++
 rtl/rand_word_fifo.sv | 66 ++++++
 rtl/random_word_packer.sv | 90 +++++++++
 tb/tb_random_word_packer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/random_word_packer_pkg.sv
// Shared defaults and sizing helper for the random word packer.
package random_word_packer_pkg;

    localparam int unsigned DEF_WORD_WIDTH = 32;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_DROP_WIDTH = 16;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned log2c(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rand_word_fifo.sv
// First-word-fall-through word buffer with occupancy count.
module rand_word_fifo
    import random_word_packer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned AW   = log2c(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Push is accepted when there is room, or when a pop frees a slot on the same edge.
    always_comb begin
        valid_o  = (count_q != '0);
        full_o   = (count_q == CW'(DEPTH));
        do_pop   = pop_i && valid_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
        count_o = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only visible through data_o when valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/random_word_packer.sv
// Packs a serial random bit stream MSB-first into words and buffers them.
module random_word_packer
    import random_word_packer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned DROP_WIDTH = DEF_DROP_WIDTH
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         ENABLE,
    input  logic                         BIT_IN,
    output logic [WORD_WIDTH-1:0]        WORD_OUT,
    output logic                         WORD_VALID,
    input  logic                         WORD_READY,
    output logic [log2c(FIFO_DEPTH):0]   FILL_LEVEL,
    output logic [DROP_WIDTH-1:0]        DROP_COUNT
);

    localparam int unsigned BCW = log2c(WORD_WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_WIDTH - 1);

    logic [1:0]            rst_sync_q;
    logic                  rst_n_int;
    // Only WORD_WIDTH-1 bits are held; the final bit goes straight into the buffer.
    logic [WORD_WIDTH-2:0] acc_q, acc_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic                  word_done;
    logic                  pop;
    logic                  fifo_full;

    // Assert reset immediately, release it two edges later.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Shift/count logic and saturating drop counter next-state.
    always_comb begin
        word_done = ENABLE && (bit_cnt_q == LAST_BIT);
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        if (ENABLE) begin
            acc_d     = {acc_q[WORD_WIDTH-3:0], BIT_IN};
            bit_cnt_d = word_done ? '0 : bit_cnt_q + BCW'(1);
        end
        pop    = WORD_VALID && WORD_READY;
        drop_d = drop_q;
        if (word_done && fifo_full && !pop && (drop_q != '1)) begin
            drop_d = drop_q + DROP_WIDTH'(1);
        end
    end

    // Packing state and drop counter.
    always_ff @(posedge CLK or negedge rst_n_int) begin
        if (!rst_n_int) begin
            acc_q     <= '0;
            bit_cnt_q <= '0;
            drop_q    <= '0;
        end else begin
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            drop_q    <= drop_d;
        end
    end

    assign DROP_COUNT = drop_q;

    rand_word_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (rst_n_int),
        .push_i  (word_done),
        .data_i  ({acc_q, BIT_IN}),
        .pop_i   (pop),
        .data_o  (WORD_OUT),
        .valid_o (WORD_VALID),
        .full_o  (fifo_full),
        .count_o (FILL_LEVEL)
    );

endmodule

// File: tb/tb_random_word_packer.sv
// Randomized and directed checks of random_word_packer against a queue-based model.
module tb_random_word_packer;

    localparam int unsigned WW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 4;

    logic          CLK;
    logic          RESET_N;
    logic          ENABLE;
    logic          BIT_IN;
    logic [WW-1:0] WORD_OUT;
    logic          WORD_VALID;
    logic          WORD_READY;
    logic [2:0]    FILL_LEVEL;
    logic [DW-1:0] DROP_COUNT;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: pending bits, buffered words, drop tally.
    bit              m_bits[$];
    bit [WW-1:0]     m_words[$];
    int unsigned     m_drop;

    random_word_packer #(
        .WORD_WIDTH (WW),
        .FIFO_DEPTH (DEPTH),
        .DROP_WIDTH (DW)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .ENABLE     (ENABLE),
        .BIT_IN     (BIT_IN),
        .WORD_OUT   (WORD_OUT),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .FILL_LEVEL (FILL_LEVEL),
        .DROP_COUNT (DROP_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_bits.delete();
        m_words.delete();
        m_drop = 0;
    endtask

    task automatic model_step(input bit en, input bit b, input bit rdy);
        bit          complete;
        bit [WW-1:0] w;
        complete = 0;
        w = '0;
        if (en) begin
            m_bits.push_back(b);
            if (m_bits.size() == WW) begin
                for (int i = 0; i < WW; i++) w[WW-1-i] = m_bits[i];
                m_bits.delete();
                complete = 1;
            end
        end
        if (rdy && m_words.size() > 0) void'(m_words.pop_front());
        if (complete) begin
            if (m_words.size() < DEPTH) m_words.push_back(w);
            else if (m_drop < (1 << DW) - 1) m_drop++;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_valid"}, 64'(WORD_VALID), 64'(m_words.size() > 0));
        check({tag, "_fill"}, 64'(FILL_LEVEL), 64'(m_words.size()));
        check({tag, "_drop"}, 64'(DROP_COUNT), 64'(m_drop));
        if (m_words.size() > 0) check({tag, "_word"}, 64'(WORD_OUT), 64'(m_words[0]));
    endtask

    task automatic cycle(input bit en, input bit b, input bit rdy);
        ENABLE     = en;
        BIT_IN     = b;
        WORD_READY = rdy;
        @(posedge CLK);
        model_step(en, b, rdy);
        #1;
        compare_all("cyc");
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        #1;
        check("rst_valid", 64'(WORD_VALID), 64'd0);
        check("rst_word", 64'(WORD_OUT), 64'd0);
        check("rst_fill", 64'(FILL_LEVEL), 64'd0);
        check("rst_drop", 64'(DROP_COUNT), 64'd0);
        model_clear();
        ENABLE = 1'b0;
        WORD_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #2 RESET_N = 1'b1;
        repeat (3) cycle(0, 0, 0);
    endtask

    task automatic send_word(input logic [WW-1:0] w, input bit rdy);
        for (int i = 0; i < WW; i++) cycle(1, w[WW-1-i], rdy);
    endtask

    initial begin
        logic [WW-1:0] ws [5];
        logic [WW-1:0] w;
        bit            rdy_bias;

        CLK = 1'b0;
        RESET_N = 1'b0;
        ENABLE = 1'b0;
        BIT_IN = 1'b0;
        WORD_READY = 1'b0;
        do_reset();

        // Single word streamed straight through.
        send_word(32'hA5A50F0F, 1);
        check("s030_word", 64'(WORD_OUT), 64'hA5A50F0F);
        check("s030_valid", 64'(WORD_VALID), 64'd1);
        cycle(0, 0, 1);
        check("s030_valid_fall", 64'(WORD_VALID), 64'd0);

        // Overflow with consumer stalled, then drain.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ws[k] = $urandom;
            send_word(ws[k], 0);
        end
        check("s031_fill", 64'(FILL_LEVEL), 64'd4);
        check("s031_drop", 64'(DROP_COUNT), 64'd1);
        check("s031_head", 64'(WORD_OUT), 64'(ws[0]));
        for (int k = 0; k < 4; k++) begin
            check("s031_drain", 64'(WORD_OUT), 64'(ws[k]));
            cycle(0, 0, 1);
        end
        check("s031_empty", 64'(WORD_VALID), 64'd0);

        // Completion while full coincides with a pop.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ws[k] = $urandom;
            send_word(ws[k], 0);
        end
        ws[4] = $urandom;
        for (int i = 0; i < WW; i++) cycle(1, ws[4][WW-1-i], i == WW - 1);
        check("s032_drop", 64'(DROP_COUNT), 64'd0);
        check("s032_fill", 64'(FILL_LEVEL), 64'd4);
        for (int k = 1; k < 5; k++) begin
            check("s032_drain", 64'(WORD_OUT), 64'(ws[k]));
            cycle(0, 0, 1);
        end
        check("s032_empty", 64'(WORD_VALID), 64'd0);

        // Enable gap in the middle of a word.
        do_reset();
        w = $urandom;
        for (int i = 0; i < 16; i++) cycle(1, w[WW-1-i], 0);
        repeat (10) cycle(0, 1'($urandom), 0);
        for (int i = 16; i < WW; i++) cycle(1, w[WW-1-i], 0);
        check("s033_word", 64'(WORD_OUT), 64'(w));
        check("s033_fill", 64'(FILL_LEVEL), 64'd1);

        // Reset in the middle of a word discards the partial bits.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(1, 1'($urandom), 0);
        do_reset();
        w = $urandom;
        send_word(w, 0);
        check("s034_word", 64'(WORD_OUT), 64'(w));
        check("s034_fill", 64'(FILL_LEVEL), 64'd1);

        // Drop counter saturation.
        do_reset();
        for (int k = 0; k < 25; k++) send_word($urandom, 0);
        check("s035_drop", 64'(DROP_COUNT), 64'hF);

        // Random traffic with a changing consumer duty cycle.
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            rdy_bias = blk[0];
            for (int n = 0; n < 400; n++) begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom),
                      rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
